pipe_chain: RTL and testbench

//  Generic N-stage pipeline register chain with per-stage valid tracking, stall with bubble insertion,

---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_stage.sv | 51 +++++
 rtl/pipe_chain.sv | 123 ++++++++++++
 tb/tb_pipe_chain.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline register chain.
package pipe_pkg;

    localparam int MAX_STAGES = 16;

    // Value a stage takes when it is flushed or receives a stall bubble.
    localparam bit BUBBLE_BIT = 1'b0;

    // Out-of-range stage indices select the last stage.
    function automatic int clamp_stage(input int idx, input int stages);
        return (idx >= stages) ? stages - 1 : idx;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline slot: valid bit plus payload, with kill > hold > bubble > load priority.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              bubble,
    input  logic              kill,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din_data,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    logic              valid_q;
    logic              valid_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    always_comb begin
        valid_d = din_valid;
        data_d  = din_data;
        if (kill) begin
            valid_d = BUBBLE_BIT;
            data_d  = {DATA_W{BUBBLE_BIT}};
        end else if (hold) begin
            valid_d = valid_q;
            data_d  = data_q;
        end else if (bubble) begin
            valid_d = BUBBLE_BIT;
            data_d  = {DATA_W{BUBBLE_BIT}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/pipe_chain.sv
// N-stage pipeline register chain with stall bubbles, partial flush and
// saturating retire/bubble statistics.
module pipe_chain
    import pipe_pkg::*;
#(
    parameter int  DATA_W = 32,
    parameter int  STAGES = 5,
    parameter int  CNT_W  = 16,
    localparam int IDX_W  = $clog2(STAGES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    input  logic                     stall,
    input  logic [IDX_W-1:0]         stall_stage,
    input  logic                     flush,
    input  logic [IDX_W-1:0]         flush_stage,
    output logic [STAGES-1:0]        stage_valid,
    output logic [STAGES*DATA_W-1:0] stage_data,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_fire,
    output logic [CNT_W-1:0]         retired_count,
    output logic [CNT_W-1:0]         bubble_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    int                stall_s;
    int                flush_f;
    logic [STAGES-1:0] hold_v;
    logic [STAGES-1:0] bubble_v;
    logic [STAGES-1:0] kill_v;
    logic [STAGES-1:0] valid_w;
    logic [DATA_W-1:0] data_w [STAGES];
    logic              bubble_ev;
    logic [CNT_W-1:0]  retired_q;
    logic [CNT_W-1:0]  retired_d;
    logic [CNT_W-1:0]  bubble_q;
    logic [CNT_W-1:0]  bubble_d;

    // A disabled chain holds every stage; flush only acts while enabled.
    always_comb begin
        stall_s  = clamp_stage(int'(stall_stage), STAGES);
        flush_f  = clamp_stage(int'(flush_stage), STAGES);
        hold_v   = '0;
        bubble_v = '0;
        kill_v   = '0;
        for (int i = 0; i < STAGES; i++) begin
            kill_v[i]   = enable && flush && (i <= flush_f);
            hold_v[i]   = !enable || (stall && (i <= stall_s));
            bubble_v[i] = stall && (i == stall_s + 1);
        end
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic              din_valid;
        logic [DATA_W-1:0] din_data;

        if (gi == 0) begin : g_head
            assign din_valid = in_valid;
            assign din_data  = in_data;
        end else begin : g_body
            assign din_valid = valid_w[gi-1];
            assign din_data  = data_w[gi-1];
        end

        pipe_stage #(
            .DATA_W(DATA_W)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .hold     (hold_v[gi]),
            .bubble   (bubble_v[gi]),
            .kill     (kill_v[gi]),
            .din_valid(din_valid),
            .din_data (din_data),
            .valid    (valid_w[gi]),
            .data     (data_w[gi])
        );

        assign stage_data[gi*DATA_W +: DATA_W] = data_w[gi];
    end

    // A bubble only counts when it displaces a live entry and survives the flush.
    always_comb begin
        out_fire  = enable && valid_w[STAGES-1]
                    && !(stall && (stall_s == STAGES - 1))
                    && !(flush && (flush_f == STAGES - 1));
        bubble_ev = enable && stall && (stall_s < STAGES - 1)
                    && valid_w[stall_s]
                    && !(flush && (stall_s + 1 <= flush_f));
        retired_d = retired_q;
        bubble_d  = bubble_q;
        if (out_fire && (retired_q != CNT_MAX)) begin
            retired_d = retired_q + CNT_W'(1);
        end
        if (bubble_ev && (bubble_q != CNT_MAX)) begin
            bubble_d = bubble_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
            bubble_q  <= '0;
        end else begin
            retired_q <= retired_d;
            bubble_q  <= bubble_d;
        end
    end

    assign in_ready      = enable && !rst && !stall;
    assign stage_valid   = valid_w;
    assign out_valid     = valid_w[STAGES-1];
    assign out_data      = data_w[STAGES-1];
    assign retired_count = retired_q;
    assign bubble_count  = bubble_q;

endmodule

// File: tb/tb_pipe_chain.sv
// Scoreboard bench for pipe_chain: a queue-based reference model predicts each cycle,
// an independent monitor compares the DUT against the predictions.
module tb_pipe_chain;

    localparam int DATA_W = 32;
    localparam int STAGES = 5;
    localparam int CNT_W  = 4;
    localparam int IDX_W  = 3;
    localparam int SD_W   = STAGES * DATA_W;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 enable;
    logic                 in_valid;
    logic [DATA_W-1:0]    in_data;
    logic                 in_ready;
    logic                 stall;
    logic [IDX_W-1:0]     stall_stage;
    logic                 flush;
    logic [IDX_W-1:0]     flush_stage;
    logic [STAGES-1:0]    stage_valid;
    logic [SD_W-1:0]      stage_data;
    logic                 out_valid;
    logic [DATA_W-1:0]    out_data;
    logic                 out_fire;
    logic [CNT_W-1:0]     retired_count;
    logic [CNT_W-1:0]     bubble_count;

    pipe_chain #(
        .DATA_W(DATA_W),
        .STAGES(STAGES),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .stall        (stall),
        .stall_stage  (stall_stage),
        .flush        (flush),
        .flush_stage  (flush_stage),
        .stage_valid  (stage_valid),
        .stage_data   (stage_data),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_fire     (out_fire),
        .retired_count(retired_count),
        .bubble_count (bubble_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              in_ready;
        logic              out_fire;
        logic [STAGES-1:0] sv;
        logic [SD_W-1:0]   sd;
        logic [CNT_W-1:0]  ret;
        logic [CNT_W-1:0]  bub;
    } exp_t;

    exp_t sb[$];

    // Reference model: the pipe as an array of {valid,data} slots, oldest at index STAGES-1.
    logic              m_valid [STAGES];
    logic [DATA_W-1:0] m_data  [STAGES];
    int                m_ret;
    int                m_bub;

    int  checks    = 0;
    int  fails     = 0;
    bit  stim_done = 0;
    bit  mon_done  = 0;

    task automatic checkOutput(input string name, input logic [SD_W-1:0] act,
                               input logic [SD_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic en, input logic iv,
                                 input logic [DATA_W-1:0] d, input logic st,
                                 input logic [IDX_W-1:0] ss, input logic fl,
                                 input logic [IDX_W-1:0] fs);
        exp_t              e;
        int                s;
        int                f;
        logic              n_valid [STAGES];
        logic [DATA_W-1:0] n_data  [STAGES];
        @(negedge clk);
        rst = r; enable = en; in_valid = iv; in_data = d;
        stall = st; stall_stage = ss; flush = fl; flush_stage = fs;

        s = (int'(ss) >= STAGES) ? STAGES - 1 : int'(ss);
        f = (int'(fs) >= STAGES) ? STAGES - 1 : int'(fs);
        e.in_ready = en && !r && !st;
        e.out_fire = en && m_valid[STAGES-1] && !(st && s == STAGES - 1)
                     && !(fl && f == STAGES - 1);

        if (r) begin
            for (int i = 0; i < STAGES; i++) begin
                m_valid[i] = 1'b0;
                m_data[i]  = '0;
            end
            m_ret = 0;
            m_bub = 0;
        end else if (en) begin
            if (e.out_fire) m_ret = (m_ret < 15) ? m_ret + 1 : 15;
            if (st && s < STAGES - 1 && m_valid[s] && !(fl && s + 1 <= f))
                m_bub = (m_bub < 15) ? m_bub + 1 : 15;
            // start from a plain one-slot shift, then overlay stall and flush effects
            n_valid[0] = iv;
            n_data[0]  = d;
            for (int i = 1; i < STAGES; i++) begin
                n_valid[i] = m_valid[i-1];
                n_data[i]  = m_data[i-1];
            end
            if (st) begin
                for (int i = 0; i <= s; i++) begin
                    n_valid[i] = m_valid[i];
                    n_data[i]  = m_data[i];
                end
                if (s + 1 < STAGES) begin
                    n_valid[s+1] = 1'b0;
                    n_data[s+1]  = '0;
                end
            end
            if (fl) begin
                for (int i = 0; i <= f; i++) begin
                    n_valid[i] = 1'b0;
                    n_data[i]  = '0;
                end
            end
            for (int i = 0; i < STAGES; i++) begin
                m_valid[i] = n_valid[i];
                m_data[i]  = n_data[i];
            end
        end

        for (int i = 0; i < STAGES; i++) begin
            e.sv[i]                 = m_valid[i];
            e.sd[i*DATA_W +: DATA_W] = m_data[i];
        end
        e.ret = CNT_W'(m_ret);
        e.bub = CNT_W'(m_bub);
        sb.push_back(e);
    endtask

    task automatic runFor(input int n, input logic iv, input logic [DATA_W-1:0] base);
        for (int k = 0; k < n; k++) applyStimulus(0, 1, iv, base + DATA_W'(k), 0, 0, 0, 0);
    endtask

    // Monitor: comb outputs just before the edge, registered outputs just after.
    initial begin : monitor
        exp_t e;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            #4;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("in_ready", SD_W'(in_ready), SD_W'(e.in_ready));
                checkOutput("out_fire", SD_W'(out_fire), SD_W'(e.out_fire));
                @(posedge clk);
                #1;
                checkOutput("stage_valid", SD_W'(stage_valid), SD_W'(e.sv));
                checkOutput("stage_data", stage_data, e.sd);
                checkOutput("out_valid", SD_W'(out_valid), SD_W'(e.sv[STAGES-1]));
                checkOutput("out_data", SD_W'(out_data), SD_W'(e.sd[SD_W-1 -: DATA_W]));
                checkOutput("retired_count", SD_W'(retired_count), SD_W'(e.ret));
                checkOutput("bubble_count", SD_W'(bubble_count), SD_W'(e.bub));
            end else if (stim_done) begin
                break;
            end
        end
        mon_done = 1;
    end

    initial begin : driver
        for (int i = 0; i < STAGES; i++) begin
            m_valid[i] = 1'b0;
            m_data[i]  = '0;
        end
        m_ret = 0;
        m_bub = 0;
        rst = 1'b1; enable = 1'b0; in_valid = 1'b0; in_data = '0;
        stall = 1'b0; stall_stage = '0; flush = 1'b0; flush_stage = '0;

        // reset, then five entries 0x11..0x15 streaming through
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
        runFor(5, 1, 32'h11);
        runFor(5, 0, 32'h0);

        // full pipe, stall up to stage 1 for two cycles
        runFor(5, 1, 32'h21);
        applyStimulus(0, 1, 1, 32'h26, 1, 3'd1, 0, 0);
        applyStimulus(0, 1, 1, 32'h26, 1, 3'd1, 0, 0);
        runFor(3, 1, 32'h26);

        // full pipe, flush stages 0..2
        runFor(5, 1, 32'h31);
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 3'd2);
        runFor(3, 0, 32'h0);

        // stall and flush together, flush covering the bubble slot
        runFor(5, 1, 32'h41);
        applyStimulus(0, 1, 1, 32'h46, 1, 3'd1, 1, 3'd3);
        runFor(2, 1, 32'h47);

        // pause mid-stream
        runFor(3, 1, 32'h51);
        for (int k = 0; k < 3; k++) applyStimulus(0, 0, 1, 32'hdead, 0, 0, 0, 0);
        runFor(5, 1, 32'h54);

        // whole-chain stall, out-of-range indices, saturation, then reset mid-stream
        applyStimulus(0, 1, 1, 32'h60, 1, 3'd7, 0, 0);
        applyStimulus(0, 1, 1, 32'h61, 0, 0, 1, 3'd6);
        runFor(22, 1, 32'h70);
        applyStimulus(1, 1, 1, 32'h99, 0, 0, 0, 0);
        runFor(3, 1, 32'h80);

        for (int k = 0; k < 400; k++) begin
            applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 7) != 0,
                          $urandom_range(0, 3) != 0, $urandom,
                          $urandom_range(0, 3) == 0, IDX_W'($urandom_range(0, 7)),
                          $urandom_range(0, 7) == 0, IDX_W'($urandom_range(0, 7)));
        end
        stim_done = 1;

        for (int k = 0; k < 100 && !mon_done; k++) @(posedge clk);
        if (!mon_done || sb.size() != 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL monitor_drain: got %0d pending expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
